instr_exec_unit: RTL and testbench
==================================

Name: instr_exec_unit

Overview:
- Downstream consumer of the instruction register.
- Accepts one instruction word (opcode, operand_a, operand_b, plus the read-pointer tag) through a valid/ready handshake and computes the signed result.
- Holds the result in an output register under a second valid/ready handshake.
- ZERO, PASSA, PASSB, ADD and SUB complete in one cycle. MULT, DIV and MOD run on a sequential shift-add / restoring-divide datapath.

Parameters:
- OP_WIDTH, 32, operand width; operands are signed two's complement.
- RES_WIDTH, 64, result width; must equal 2*OP_WIDTH.
- ADDR_WIDTH, 5, width of the instruction tag echoed with the result.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- in_valid  input  1  instruction word present.
- in_ready  output  1  unit can accept an instruction.
- in_opcode  input  3  0=ZERO 1=PASSA 2=PASSB 3=ADD 4=SUB 5=MULT 6=DIV 7=MOD.
- in_operand_a  input  OP_WIDTH  signed operand A.
- in_operand_b  input  OP_WIDTH  signed operand B.
- in_addr  input  ADDR_WIDTH  instruction tag (register read pointer).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_result  output  RES_WIDTH  signed result.
- out_addr  output  ADDR_WIDTH  tag of the instruction that produced out_result.
- out_div_zero  output  1  DIV/MOD with operand_b==0.
- busy  output  1  high in CALC or DONE.

Behaviour:
- States: IDLE, CALC, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
- Reset (reset_n low at posedge):
  - state <= IDLE; out_result, out_addr, out_div_zero, iteration counter and datapath registers <= 0.
  - Any in-flight operation is aborted, including mid-CALC or mid-DONE; no output is produced for it.
- Accept: in_valid && in_ready at posedge. The opcode, operands and tag are captured; later input changes are ignored until the next accept.
- Single-cycle ops (ZERO, PASSA, PASSB, ADD, SUB):
  - IDLE -> DONE at the accepting edge; out_valid is high the cycle after the accept.
  - ZERO=0; PASSA and PASSB are the operand sign-extended to RES_WIDTH.
  - ADD and SUB are computed at RES_WIDTH on sign-extended operands, so there is no overflow.
- MULT:
  - IDLE -> CALC; OP_WIDTH iterations on operand magnitudes, then sign correction.
  - CALC -> DONE after exactly OP_WIDTH cycles; out_valid rises OP_WIDTH+1 cycles after the accept.
  - Result is the full signed product.
- DIV/MOD:
  - Same timing as MULT; restoring division on magnitudes.
  - Quotient truncates toward zero; remainder takes the sign of operand_a. Both are sign-extended to RES_WIDTH.
  - Most-negative / -1 yields +2^(OP_WIDTH-1) with no overflow.
- Divide by zero: DIV or MOD with operand_b==0 goes IDLE -> DONE directly (1-cycle latency) with out_result=0 and out_div_zero=1. out_div_zero is 0 for every other result.
- DONE:
  - out_result, out_addr and out_div_zero are held stable while out_valid && !out_ready.
  - On out_valid && out_ready the state goes to IDLE; the output registers keep their last values.
  - No new accept happens in the same cycle (in_ready is low in DONE), so throughput is at most 1 instruction per 2 cycles.
- in_valid while busy is ignored; the upstream stage holds the word until in_ready.

Optional Feature:
- Macro: EXEC_FAST_MULT_EN.
- Defined: MULT uses a single-cycle signed multiplier. Timing matches ADD (IDLE -> DONE, out_valid the cycle after the accept); results are bit-identical.
- Undefined: MULT uses the iterative OP_WIDTH-cycle path described above.
- DIV and MOD are iterative in both builds.

Test Plan:
- Reset then idle: hold reset_n=0 for 2 cycles, release -> in_ready=1, out_valid=0, out_result=0, out_addr=0, out_div_zero=0, busy=0.
- ADD a=7 b=-10 tag=3 with out_ready=1 -> one cycle later out_valid=1, out_result=-3 (64-bit), out_addr=3, then in_ready=1 the next cycle. SUB a=-2^31 b=1 -> out_result=-2147483649.
- MULT a=-46341 b=46341 tag=9:
  - Without macro: out_valid exactly 33 cycles after the accept, out_result=-2147488281.
  - With EXEC_FAST_MULT_EN: out_valid 1 cycle after the accept, same value.
- DIV a=-17 b=5 -> -3; MOD a=-17 b=5 -> -2; DIV a=-2^31 b=-1 -> +2147483648. Each is 33 cycles after the accept, out_div_zero=0.
- DIV a=100 b=0 tag=31 -> one cycle later out_valid=1, out_result=0, out_div_zero=1, out_addr=31.
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_valid ignored; then out_ready=1 -> IDLE.
  - Start MULT, assert reset_n=0 at CALC cycle 10 -> next cycle IDLE with all outputs 0 and no result emitted.

Source files
------------

// File: rtl/instr_exec_unit.sv
// Instruction execution unit: single-cycle ALU ops plus iterative shift-add MULT and restoring DIV/MOD.
// Optional EXEC_FAST_MULT_EN replaces the iterative MULT with a single-cycle multiplier.
module instr_exec_unit #(
    parameter int OP_WIDTH   = 32,
    parameter int RES_WIDTH  = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_opcode,
    input  logic [OP_WIDTH-1:0]   in_operand_a,
    input  logic [OP_WIDTH-1:0]   in_operand_b,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RES_WIDTH-1:0]  out_result,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_div_zero,
    output logic                  busy
);

    // Both ports use strict valid/ready: a transfer happens only on a posedge where
    // valid && ready; the producer holds its word stable until that edge.

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    localparam int              CNT_W    = $clog2(OP_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic                  neg_q, neg_d;
    logic [OP_WIDTH-1:0]   hi_q, hi_d;
    logic [OP_WIDTH-1:0]   lo_q, lo_d;
    logic [OP_WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RES_WIDTH-1:0]  out_result_q, out_result_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  out_div_zero_q, out_div_zero_d;

    logic                  a_sign, b_sign;
    logic [OP_WIDTH-1:0]   a_mag, b_mag;
    logic [RES_WIDTH-1:0]  a_ext, b_ext;
    logic [OP_WIDTH:0]     mul_sum;
    logic [OP_WIDTH-1:0]   mul_hi, mul_lo;
    logic [OP_WIDTH-1:0]   div_shift;
    logic [OP_WIDTH:0]     div_diff;
    logic [OP_WIDTH-1:0]   div_hi, div_lo;
    logic [RES_WIDTH-1:0]  mag_res, calc_res;
    logic                  go_done, imm_dz;
    logic [RES_WIDTH-1:0]  imm_res;

    assign a_sign = in_operand_a[OP_WIDTH-1];
    assign b_sign = in_operand_b[OP_WIDTH-1];
    assign a_mag  = a_sign ? (~in_operand_a + OP_WIDTH'(1)) : in_operand_a;
    assign b_mag  = b_sign ? (~in_operand_b + OP_WIDTH'(1)) : in_operand_b;
    assign a_ext  = {{(RES_WIDTH-OP_WIDTH){a_sign}}, in_operand_a};
    assign b_ext  = {{(RES_WIDTH-OP_WIDTH){b_sign}}, in_operand_b};

    // Shift-add step: hi:lo is the partial product, lo shifts out the multiplier bits.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    assign mul_hi  = mul_sum[OP_WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[OP_WIDTH-1:1]};

    // Restoring step: remainder stays below the divisor (<= 2^(W-1)), so its MSB is always 0.
    assign div_shift = {hi_q[OP_WIDTH-2:0], lo_q[OP_WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {1'b0, dvs_q};
    assign div_hi    = div_diff[OP_WIDTH] ? div_shift : div_diff[OP_WIDTH-1:0];
    assign div_lo    = {lo_q[OP_WIDTH-2:0], ~div_diff[OP_WIDTH]};

    always_comb begin
        if (op_q == OP_MULT) begin
            mag_res = {mul_hi, mul_lo};
        end else if (op_q == OP_DIV) begin
            mag_res = {{(RES_WIDTH-OP_WIDTH){1'b0}}, div_lo};
        end else begin
            mag_res = {{(RES_WIDTH-OP_WIDTH){1'b0}}, div_hi};
        end
        calc_res = neg_q ? (~mag_res + RES_WIDTH'(1)) : mag_res;
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        neg_d          = neg_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        dvs_d          = dvs_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        out_result_d   = out_result_q;
        out_addr_d     = out_addr_q;
        out_div_zero_d = out_div_zero_q;
        go_done        = 1'b0;
        imm_dz         = 1'b0;
        imm_res        = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    addr_d  = in_addr;
                    op_d    = in_opcode;
                    hi_d    = '0;
                    cnt_d   = '0;
                    go_done = 1'b1;
                    case (in_opcode)
                        OP_ZERO:  imm_res = '0;
                        OP_PASSA: imm_res = a_ext;
                        OP_PASSB: imm_res = b_ext;
                        OP_ADD:   imm_res = a_ext + b_ext;
                        OP_SUB:   imm_res = a_ext - b_ext;
                        OP_MULT: begin
`ifdef EXEC_FAST_MULT_EN
                            // Low RES_WIDTH bits of the sign-extended product are the signed product.
                            imm_res = a_ext * b_ext;
`else
                            go_done = 1'b0;
                            dvs_d   = a_mag;
                            lo_d    = b_mag;
                            neg_d   = a_sign ^ b_sign;
`endif
                        end
                        default: begin
                            if (in_operand_b == '0) begin
                                imm_dz = 1'b1;
                            end else begin
                                go_done = 1'b0;
                                dvs_d   = b_mag;
                                lo_d    = a_mag;
                                neg_d   = (in_opcode == OP_MOD) ? a_sign : (a_sign ^ b_sign);
                            end
                        end
                    endcase
                    if (go_done) begin
                        state_d        = S_DONE;
                        out_result_d   = imm_res;
                        out_addr_d     = in_addr;
                        out_div_zero_d = imm_dz;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q == OP_MULT) begin
                    hi_d = mul_hi;
                    lo_d = mul_lo;
                end else begin
                    hi_d = div_hi;
                    lo_d = div_lo;
                end
                // Sign correction is folded into the final iteration.
                if (cnt_q == CNT_LAST) begin
                    state_d        = S_DONE;
                    out_result_d   = calc_res;
                    out_addr_d     = addr_q;
                    out_div_zero_d = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            neg_q          <= 1'b0;
            hi_q           <= '0;
            lo_q           <= '0;
            dvs_q          <= '0;
            cnt_q          <= '0;
            addr_q         <= '0;
            out_result_q   <= '0;
            out_addr_q     <= '0;
            out_div_zero_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            neg_q          <= neg_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            dvs_q          <= dvs_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            out_result_q   <= out_result_d;
            out_addr_q     <= out_addr_d;
            out_div_zero_q <= out_div_zero_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign out_result   = out_result_q;
    assign out_addr     = out_addr_q;
    assign out_div_zero = out_div_zero_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed table-driven bench for instr_exec_unit, plus backpressure and mid-CALC reset sequences.
module tb_instr_exec_unit;

    localparam int OPW  = 32;
    localparam int RESW = 64;
    localparam int AW   = 5;
`ifdef EXEC_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int NVEC    = 19;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_opcode;
    logic [OPW-1:0]  in_operand_a;
    logic [OPW-1:0]  in_operand_b;
    logic [AW-1:0]   in_addr;
    logic            out_valid;
    logic            out_ready;
    logic [RESW-1:0] out_result;
    logic [AW-1:0]   out_addr;
    logic            out_div_zero;
    logic            busy;

    int n_vec    = 0;
    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [2:0]      op;
        logic [OPW-1:0]  a;
        logic [OPW-1:0]  b;
        logic [AW-1:0]   tag;
        logic [RESW-1:0] res;
        logic            dz;
        int              lat;
    } vec_t;

    vec_t vecs[NVEC];

    instr_exec_unit #(.OP_WIDTH(OPW), .RES_WIDTH(RESW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_operand_a (in_operand_a),
        .in_operand_b (in_operand_b),
        .in_addr      (in_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_addr     (out_addr),
        .out_div_zero (out_div_zero),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [RESW-1:0] act, input logic [RESW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int lat;
        n_vec++;
        @(negedge clk);
        check($sformatf("v%0d_in_ready_pre", idx), RESW'(in_ready), 64'd1);
        in_valid     = 1'b1;
        in_opcode    = v.op;
        in_operand_a = v.a;
        in_operand_b = v.b;
        in_addr      = v.tag;
        out_ready    = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs after the accept; the captured word must be used.
        in_valid     = 1'b0;
        in_opcode    = 3'($urandom_range(0, 7));
        in_operand_a = $urandom;
        in_operand_b = $urandom;
        in_addr      = AW'($urandom_range(0, 31));
        check($sformatf("v%0d_busy", idx), RESW'(busy), 64'd1);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d_latency", idx), RESW'(lat), RESW'(v.lat));
        check($sformatf("v%0d_result", idx), out_result, v.res);
        check($sformatf("v%0d_addr", idx), RESW'(out_addr), RESW'(v.tag));
        check($sformatf("v%0d_div_zero", idx), RESW'(out_div_zero), RESW'(v.dz));
        @(posedge clk);
        #1;
        check($sformatf("v%0d_in_ready_post", idx), RESW'(in_ready), 64'd1);
        check($sformatf("v%0d_out_valid_post", idx), RESW'(out_valid), 64'd0);
    endtask

    initial begin
        logic [2:0] abort_op;
        int seen;

        vecs[0]  = '{3'd3, 32'sd7, -32'sd10, 5'd3, -64'sd3, 1'b0, 1};
        vecs[1]  = '{3'd4, 32'h8000_0000, 32'sd1, 5'd4, -64'sd2147483649, 1'b0, 1};
        vecs[2]  = '{3'd5, -32'sd46341, 32'sd46341, 5'd9, -64'sd2147488281, 1'b0, MUL_LAT};
        vecs[3]  = '{3'd6, -32'sd17, 32'sd5, 5'd10, -64'sd3, 1'b0, DIV_LAT};
        vecs[4]  = '{3'd7, -32'sd17, 32'sd5, 5'd11, -64'sd2, 1'b0, DIV_LAT};
        vecs[5]  = '{3'd6, 32'h8000_0000, -32'sd1, 5'd12, 64'sd2147483648, 1'b0, DIV_LAT};
        vecs[6]  = '{3'd6, 32'sd100, 32'sd0, 5'd31, 64'd0, 1'b1, 1};
        vecs[7]  = '{3'd0, 32'sd5, 32'sd6, 5'd1, 64'd0, 1'b0, 1};
        vecs[8]  = '{3'd1, -32'sd1, 32'sd6, 5'd2, -64'sd1, 1'b0, 1};
        vecs[9]  = '{3'd2, 32'sd3, 32'h7fff_ffff, 5'd5, 64'sd2147483647, 1'b0, 1};
        vecs[10] = '{3'd7, 32'sd17, -32'sd5, 5'd6, 64'sd2, 1'b0, DIV_LAT};
        vecs[11] = '{3'd5, 32'h7fff_ffff, 32'h7fff_ffff, 5'd7, 64'sd4611686014132420609, 1'b0, MUL_LAT};
        vecs[12] = '{3'd5, 32'h8000_0000, 32'h8000_0000, 5'd8, 64'sd4611686018427387904, 1'b0, MUL_LAT};
        vecs[13] = '{3'd6, 32'sd7, 32'sd9, 5'd13, 64'd0, 1'b0, DIV_LAT};
        vecs[14] = '{3'd7, 32'sd7, 32'sd9, 5'd14, 64'sd7, 1'b0, DIV_LAT};
        vecs[15] = '{3'd7, 32'h8000_0000, -32'sd1, 5'd15, 64'd0, 1'b0, DIV_LAT};
        vecs[16] = '{3'd7, 32'sd5, 32'sd0, 5'd16, 64'd0, 1'b1, 1};
        vecs[17] = '{3'd6, 32'h8000_0000, 32'sd2, 5'd17, -64'sd1073741824, 1'b0, DIV_LAT};
        vecs[18] = '{3'd3, 32'h7fff_ffff, 32'h7fff_ffff, 5'd18, 64'sd4294967294, 1'b0, 1};

        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_opcode    = '0;
        in_operand_a = '0;
        in_operand_b = '0;
        in_addr      = '0;
        out_ready    = 1'b1;

        // Reset then idle
        n_vec++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", RESW'(in_ready), 64'd1);
        check("rst_out_valid", RESW'(out_valid), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_addr", RESW'(out_addr), 64'd0);
        check("rst_out_div_zero", RESW'(out_div_zero), 64'd0);
        check("rst_busy", RESW'(busy), 64'd0);

        for (int i = 0; i < NVEC; i++) begin
            apply_vec(vecs[i], i);
        end

        // Backpressure: result held for 5 cycles while in_valid is ignored
        n_vec++;
        @(negedge clk);
        in_valid     = 1'b1;
        in_opcode    = 3'd3;
        in_operand_a = 32'sd1;
        in_operand_b = 32'sd2;
        in_addr      = 5'd6;
        out_ready    = 1'b0;
        @(posedge clk);
        #1;
        in_opcode    = 3'd1;
        in_operand_a = 32'sd99;
        in_addr      = 5'd20;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_out_valid", c), RESW'(out_valid), 64'd1);
            check($sformatf("bp%0d_in_ready", c), RESW'(in_ready), 64'd0);
            check($sformatf("bp%0d_result", c), out_result, 64'd3);
            check($sformatf("bp%0d_addr", c), RESW'(out_addr), 64'd6);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", RESW'(in_ready), 64'd1);
        check("bp_release_out_valid", RESW'(out_valid), 64'd0);
        check("bp_release_result_kept", out_result, 64'd3);
        check("bp_release_addr_kept", RESW'(out_addr), 64'd6);

        // Abort: reset asserted at CALC cycle 10 of an iterative op
        n_vec++;
`ifdef EXEC_FAST_MULT_EN
        abort_op = 3'd6;
`else
        abort_op = 3'd5;
`endif
        @(negedge clk);
        in_valid     = 1'b1;
        in_opcode    = abort_op;
        in_operand_a = 32'sd1234;
        in_operand_b = 32'sd56;
        in_addr      = 5'd21;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy_before", RESW'(busy), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_ready", RESW'(in_ready), 64'd1);
        check("abort_out_valid", RESW'(out_valid), 64'd0);
        check("abort_busy", RESW'(busy), 64'd0);
        check("abort_out_result", out_result, 64'd0);
        check("abort_out_addr", RESW'(out_addr), 64'd0);
        check("abort_out_div_zero", RESW'(out_div_zero), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", RESW'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
